// File: rtl/cpu_regfile_sb.sv
//------------------------------------------------------------------------------
// Module   : cpu_regfile_sb
// Brief    : 2W/2R register file with FP/SP taps, post-reset clear sequencer,
//            optional write-to-read bypass, busy scoreboard, conflict detect.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cpu_regfile_sb #(
  parameter int DATA_W         = 32,
  parameter int NUM_REGS       = 16,
  parameter int ADDR_W         = 4,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int FP_IDX         = 0,
  parameter int SP_IDX         = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] waddr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] waddr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic [ADDR_W-1:0] raddr0_i,
  output logic [DATA_W-1:0] rdata0_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] fp_o,
  output logic [DATA_W-1:0] sp_o,
  input  logic              rsv_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic              busy0_o,
  output logic              busy1_o,
  output logic              ready_o,
  output logic              conflict_o
);

  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_FP_ADDR  = ADDR_W'(FP_IDX);
  localparam logic [ADDR_W-1:0] c_SP_ADDR  = ADDR_W'(SP_IDX);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_clr_idx;
  logic                w_clr_we;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_conflict;
  logic                w_run;
  logic                w_we0;
  logic                w_we1;

  assign w_run = rst_i && (r_state == ST_RUN);
  assign w_we0 = w_run && we0_i;
  assign w_we1 = w_run && we1_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= ST_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_we) begin
        r_clr_idx <= r_clr_idx + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          w_clr_we = 1'b1;
          if (r_clr_idx == c_LAST_IDX) begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // Port 1 is written after port 0 so it wins on an index collision.
  always_ff @(posedge clk_i) begin
    if (rst_i && w_clr_we) begin
      r_regs[r_clr_idx] <= '0;
    end else begin
      if (w_we0) begin
        r_regs[waddr0_i] <= wdata0_i;
      end
      if (w_we1) begin
        r_regs[waddr1_i] <= wdata1_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_we0 && w_we1 && (waddr0_i == waddr1_i);
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_run && rsv_i && (rsv_addr_i == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_we0 && (waddr0_i == ADDR_W'(i))) ||
                     (w_we1 && (waddr1_i == ADDR_W'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  logic [3:0][ADDR_W-1:0] w_tap_addr;
  assign w_tap_addr = {c_SP_ADDR, c_FP_ADDR, raddr1_i, raddr0_i};

  for (genvar t = 0; t < 4; t++) begin : g_tap
    logic [DATA_W-1:0] w_data;
    always_comb begin
      w_data = r_regs[w_tap_addr[t]];
      if (BYPASS != 0) begin
        if (w_we1 && (waddr1_i == w_tap_addr[t])) begin
          w_data = wdata1_i;
        end else if (w_we0 && (waddr0_i == w_tap_addr[t])) begin
          w_data = wdata0_i;
        end
      end
      if (!rst_i) begin
        w_data = '0;
      end
    end
  end

  assign rdata0_o   = g_tap[0].w_data;
  assign rdata1_o   = g_tap[1].w_data;
  assign fp_o       = g_tap[2].w_data;
  assign sp_o       = g_tap[3].w_data;
  assign busy0_o    = rst_i && r_busy[raddr0_i];
  assign busy1_o    = rst_i && r_busy[raddr1_i];
  assign ready_o    = w_run;
  assign conflict_o = r_conflict;

endmodule

`default_nettype wire

// File: tb/tb_cpu_regfile_sb.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_regfile_sb
// Brief    : directed self-checking bench for cpu_regfile_sb.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_regfile_sb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        we0_i, we1_i, rsv_i;
  logic [3:0]  waddr0_i, waddr1_i, raddr0_i, raddr1_i, rsv_addr_i;
  logic [31:0] wdata0_i, wdata1_i;

  logic [31:0] rd0_a, rd1_a, fp_a, sp_a, rd0_b, rd1_b, fp_b, sp_b, rd0_c, rd1_c, fp_c, sp_c;
  logic        b0_a, b1_a, rdy_a, cf_a, b0_b, b1_b, rdy_b, cf_b, b0_c, b1_c, rdy_c, cf_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  cpu_regfile_sb dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .raddr0_i(raddr0_i), .rdata0_o(rd0_a), .raddr1_i(raddr1_i), .rdata1_o(rd1_a),
    .fp_o(fp_a), .sp_o(sp_a), .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i),
    .busy0_o(b0_a), .busy1_o(b1_a), .ready_o(rdy_a), .conflict_o(cf_a)
  );

  cpu_regfile_sb #(.BYPASS(0), .FP_IDX(14), .SP_IDX(15)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .raddr0_i(raddr0_i), .rdata0_o(rd0_b), .raddr1_i(raddr1_i), .rdata1_o(rd1_b),
    .fp_o(fp_b), .sp_o(sp_b), .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i),
    .busy0_o(b0_b), .busy1_o(b1_b), .ready_o(rdy_b), .conflict_o(cf_b)
  );

  cpu_regfile_sb #(.CLEAR_ON_RESET(0)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i),
    .we0_i(we0_i), .waddr0_i(waddr0_i), .wdata0_i(wdata0_i),
    .we1_i(we1_i), .waddr1_i(waddr1_i), .wdata1_i(wdata1_i),
    .raddr0_i(raddr0_i), .rdata0_o(rd0_c), .raddr1_i(raddr1_i), .rdata1_o(rd1_c),
    .fp_o(fp_c), .sp_o(sp_c), .rsv_i(rsv_i), .rsv_addr_i(rsv_addr_i),
    .busy0_o(b0_c), .busy1_o(b1_c), .ready_o(rdy_c), .conflict_o(cf_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    we0_i = 1'b0; we1_i = 1'b0; rsv_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; idle();
    waddr0_i = '0; waddr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    raddr0_i = 4'd3; raddr1_i = 4'd4; rsv_addr_i = '0;

    // Reset held for three cycles: every output forced low.
    repeat (3) tick();
    chk("rst_ready", {31'd0, rdy_a}, 32'd0);
    chk("rst_rdata0", rd0_a, 32'd0);
    chk("rst_fp", fp_a, 32'd0);
    chk("rst_busy0", {31'd0, b0_a}, 32'd0);
    chk("rst_conflict", {31'd0, cf_a}, 32'd0);

    // Release with writes and a reservation pending; all must be dropped in CLEAR.
    rst_i = 1'b1;
    we0_i = 1'b1; waddr0_i = 4'd3; wdata0_i = 32'hAAAA_AAAA;
    we1_i = 1'b1; waddr1_i = 4'd4; wdata1_i = 32'hBBBB_BBBB;
    rsv_i = 1'b1; rsv_addr_i = 4'd2;
    #1;
    chk("noclr_ready_pre", {31'd0, rdy_c}, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("clear_ready", {31'd0, rdy_a}, 32'd0);
      if (k == 1) chk("noclr_ready", {31'd0, rdy_c}, 32'd1);
    end
    idle();
    tick();
    chk("clear_ready16", {31'd0, rdy_a}, 32'd1);
    raddr1_i = 4'd2;
    #1;
    chk("clear_r3", rd0_a, 32'd0);
    chk("clear_fp", fp_a, 32'd0);
    chk("clear_sp", sp_a, 32'd0);
    chk("clear_busy_r2", {31'd0, b1_a}, 32'd0);
    raddr1_i = 4'd4;
    #1;
    chk("clear_r4", rd1_a, 32'd0);

    // Single write with bypass vs. no bypass.
    we0_i = 1'b1; waddr0_i = 4'd3; wdata0_i = 32'hDEAD_BEEF; raddr0_i = 4'd3;
    #1;
    chk("byp1_same", rd0_a, 32'hDEAD_BEEF);
    chk("byp0_same", rd0_b, 32'd0);
    tick(); idle(); #1;
    chk("byp1_next", rd0_a, 32'hDEAD_BEEF);
    chk("byp0_next", rd0_b, 32'hDEAD_BEEF);

    // Both ports hit r5: port 1 wins, conflict pulses once.
    we0_i = 1'b1; waddr0_i = 4'd5; wdata0_i = 32'h1111_1111;
    we1_i = 1'b1; waddr1_i = 4'd5; wdata1_i = 32'h2222_2222; raddr0_i = 4'd5;
    #1;
    chk("conf_pre", {31'd0, cf_a}, 32'd0);
    chk("conf_byp", rd0_a, 32'h2222_2222);
    tick(); idle(); #1;
    chk("conf_pulse", {31'd0, cf_a}, 32'd1);
    chk("conf_r5", rd0_a, 32'h2222_2222);
    chk("conf_r5_b", rd0_b, 32'h2222_2222);
    tick();
    chk("conf_end", {31'd0, cf_a}, 32'd0);

    // FP/SP taps, default and overridden indices.
    we0_i = 1'b1; waddr0_i = 4'd1; wdata0_i = 32'h0000_1000;
    we1_i = 1'b1; waddr1_i = 4'd0; wdata1_i = 32'h0000_2000;
    #1;
    chk("sp_byp", sp_a, 32'h0000_1000);
    chk("fp_byp", fp_a, 32'h0000_2000);
    tick(); idle(); #1;
    chk("sp_a", sp_a, 32'h0000_1000);
    chk("fp_a", fp_a, 32'h0000_2000);
    chk("no_conf", {31'd0, cf_a}, 32'd0);
    chk("fp_b_pre", fp_b, 32'd0);
    we0_i = 1'b1; waddr0_i = 4'd14; wdata0_i = 32'h0000_E000;
    we1_i = 1'b1; waddr1_i = 4'd15; wdata1_i = 32'h0000_F000;
    #1;
    chk("fp_b_same", fp_b, 32'd0);
    tick(); idle(); #1;
    chk("fp_b", fp_b, 32'h0000_E000);
    chk("sp_b", sp_b, 32'h0000_F000);
    chk("fp_a_kept", fp_a, 32'h0000_2000);

    // Scoreboard: reserve, clear by write, and set-wins collision.
    raddr0_i = 4'd7; rsv_i = 1'b1; rsv_addr_i = 4'd7;
    #1;
    chk("busy_no_byp", {31'd0, b0_a}, 32'd0);
    tick(); idle(); #1;
    chk("busy_set", {31'd0, b0_a}, 32'd1);
    we0_i = 1'b1; waddr0_i = 4'd7; wdata0_i = 32'h0000_0077;
    #1;
    chk("busy_hold", {31'd0, b0_a}, 32'd1);
    tick(); idle(); #1;
    chk("busy_clr", {31'd0, b0_a}, 32'd0);
    rsv_i = 1'b1; rsv_addr_i = 4'd7;
    we1_i = 1'b1; waddr1_i = 4'd7; wdata1_i = 32'h0000_0777;
    tick(); idle(); #1;
    chk("busy_setwins", {31'd0, b0_a}, 32'd1);
    chk("busy_data", rd0_a, 32'h0000_0777);

    // Reset again, then interrupt the clear at clr_idx = 9.
    rst_i = 1'b0;
    #1;
    chk("rst2_rdata", rd0_a, 32'd0);
    chk("rst2_busy_forced", {31'd0, b0_a}, 32'd0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("rst2_busy_cleared", {31'd0, b0_a}, 32'd0);
    repeat (9) tick();
    chk("mid_ready", {31'd0, rdy_a}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("mid_rdata", rd0_a, 32'd0);
    tick();
    rst_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("restart_ready", {31'd0, rdy_a}, (k == 16) ? 32'd1 : 32'd0);
    end
    raddr1_i = 4'd5;
    #1;
    chk("restart_r7", rd0_a, 32'd0);
    chk("restart_r5", rd1_a, 32'd0);
    chk("restart_sp", sp_a, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
